midi_uart_rx: RTL and testbench



---
 rtl/midi_pkg.sv | 37 +++
 rtl/midi_baud_tick.sv | 46 ++++
 rtl/midi_uart_rx.sv | 180 ++++++++++++++++++
 tb/tb_midi_uart_rx.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
//==============================================================================
// Module      : midi_pkg
// Description : Shared MIDI constants: line rate, receiver state encoding and
//               status-byte values used by the message FSM.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package midi_pkg;

    localparam int MIDI_BAUD = 31250;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_t;

    localparam logic [7:0] c_STATUS_NOTE_OFF   = 8'h80;
    localparam logic [7:0] c_STATUS_NOTE_ON    = 8'h90;
    localparam logic [7:0] c_STATUS_POLY_AT    = 8'hA0;
    localparam logic [7:0] c_STATUS_CTRL_CHG   = 8'hB0;
    localparam logic [7:0] c_STATUS_PROG_CHG   = 8'hC0;
    localparam logic [7:0] c_STATUS_CHAN_AT    = 8'hD0;
    localparam logic [7:0] c_STATUS_PITCH_BEND = 8'hE0;
    localparam logic [7:0] c_STATUS_SYSEX      = 8'hF0;
    localparam logic [7:0] c_STATUS_EOX        = 8'hF7;

    function automatic logic is_status(input logic [7:0] b);
        return b[7];
    endfunction

endpackage

`default_nettype wire

// File: rtl/midi_baud_tick.sv
//==============================================================================
// Module      : midi_baud_tick
// Description : Free-running divider producing one-clk ticks at BAUD*OVS Hz.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module midi_baud_tick #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 31250,
    parameter int OVS      = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int DIV = CLK_FREQ / (BAUD * OVS);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    if (DIV < 1) begin : g_div_check
        $error("midi_baud_tick: CLK_FREQ too low for BAUD*OVS");
    end

    localparam logic [CW-1:0] c_LAST = CW'(DIV - 1);

    logic [CW-1:0] div_q;
    logic [CW-1:0] div_d;

    assign tick = (div_q == c_LAST);

    always_comb begin
        div_d = tick ? '0 : div_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/midi_uart_rx.sv
//==============================================================================
// Module      : midi_uart_rx
// Description : MIDI IN receiver, 8N1 LSB first, 16x oversampled with start
//               glitch rejection. Optional MIDI_RX_FERR_EN adds ferr/err_cnt.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module midi_uart_rx
    import midi_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = MIDI_BAUD,
    parameter int OVS      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       dv,
    output logic       busy
`ifdef MIDI_RX_FERR_EN
    ,
    output logic       ferr,
    output logic [7:0] err_cnt
`endif
);

    if ((OVS % 2) != 0 || OVS < 8) begin : g_ovs_check
        $error("midi_uart_rx: OVS must be even and >= 8");
    end

    localparam int CW = $clog2(OVS);
    localparam logic [CW-1:0] c_HALF = CW'(OVS / 2 - 1);
    localparam logic [CW-1:0] c_LAST = CW'(OVS - 1);

    logic            sync1_q, sync2_q, rxs, tick;
    rx_state_t       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            dv_q, dv_d;
`ifdef MIDI_RX_FERR_EN
    logic            ferr_q, ferr_d;
    logic [7:0]      err_q;
`endif

    midi_baud_tick #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .OVS      (OVS)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Synchroniser resets to the idle level so reset never fakes a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end
    assign rxs = sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        dv_d    = 1'b0;
`ifdef MIDI_RX_FERR_EN
        ferr_d  = 1'b0;
`endif
        if (tick) begin
            case (state_q)
                RX_IDLE: begin
                    if (!rxs) begin
                        state_d = RX_START;
                        cnt_d   = '0;
                    end
                end
                RX_START: begin
                    if (cnt_q == c_HALF) begin
                        cnt_d = '0;
                        bit_d = '0;
                        state_d = rxs ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt_q == c_LAST) begin
                        cnt_d   = '0;
                        shift_d = {rxs, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_d = RX_STOP;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                RX_STOP: begin
                    // Leaving mid-stop-bit lets a back-to-back start edge be caught.
                    if (cnt_q == c_LAST) begin
                        cnt_d = '0;
                        if (rxs) begin
                            data_d  = shift_q;
                            dv_d    = 1'b1;
                            state_d = RX_IDLE;
                        end else begin
`ifdef MIDI_RX_FERR_EN
                            ferr_d  = 1'b1;
`endif
                            state_d = RX_BREAK;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                RX_BREAK: begin
                    if (rxs) begin
                        state_d = RX_IDLE;
                    end
                end
                default: begin
                    state_d = RX_IDLE;
                end
            endcase
        end
    end

`ifdef MIDI_RX_FERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ferr_q <= 1'b0;
            err_q  <= '0;
        end else begin
            ferr_q <= ferr_d;
            if (ferr_d && err_q != 8'hFF) begin
                err_q <= err_q + 8'd1;
            end
        end
    end
    assign ferr    = ferr_q;
    assign err_cnt = err_q;
`endif

    assign data = data_q;
    assign dv   = dv_q;
    assign busy = (state_q != RX_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_midi_uart_rx.sv
//==============================================================================
// Module      : tb_midi_uart_rx
// Description : Directed self-checking bench for midi_uart_rx (DIV=10, 160-clk bit).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_midi_uart_rx;

    localparam int CLK_FREQ = 5000000;
    localparam int BAUD     = 31250;
    localparam int OVS      = 16;
    localparam int BITP     = 160;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       dv;
    logic       busy;
`ifdef MIDI_RX_FERR_EN
    logic       ferr;
    logic [7:0] err_cnt;
`endif

    midi_uart_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .OVS      (OVS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx),
        .data    (data),
        .dv      (dv),
        .busy    (busy)
`ifdef MIDI_RX_FERR_EN
        ,
        .ferr    (ferr),
        .err_cnt (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int dv_cnt   = 0;
    int ferr_cnt = 0;
    logic [7:0] dv_data[$];
    int         dv_time[$];
    logic       dv_prev = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (dv === 1'b1) begin
            dv_cnt++;
            dv_data.push_back(data);
            dv_time.push_back(cyc);
            check_eq("dv_single_cycle", {31'd0, dv_prev}, 32'd0);
        end
        dv_prev = dv;
`ifdef MIDI_RX_FERR_EN
        if (ferr === 1'b1) ferr_cnt++;
`endif
    end

    function automatic logic [7:0] qd(input int i);
        return (i < dv_data.size()) ? dv_data[i] : 8'hxx;
    endfunction

    function automatic int qt(input int i);
        return (i < dv_time.size()) ? dv_time[i] : -100000;
    endfunction

    task automatic clear_log();
        dv_cnt   = 0;
        ferr_cnt = 0;
        dv_data.delete();
        dv_time.delete();
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input int bp, input logic stopv);
        rx = 1'b0;
        repeat (bp) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (bp) @(negedge clk);
        end
        rx = stopv;
        repeat (bp) @(negedge clk);
    endtask

    function automatic logic in_range(input int d);
        return (d >= 1590) && (d <= 1610);
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int bps[2];
        bps[0] = 156;
        bps[1] = 164;

        rx  = 1'b1;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("reset_data", {24'd0, data}, 32'h00);
        check_eq("reset_dv",   {31'd0, dv},   32'd0);
        check_eq("reset_busy", {31'd0, busy}, 32'd0);
`ifdef MIDI_RX_FERR_EN
        check_eq("reset_err_cnt", {24'd0, err_cnt}, 32'd0);
`endif
        rst = 1'b0;
        idle(50);

        clear_log();
        send(8'h90, BITP, 1'b1);
        idle(1000);
        check_eq("single_dv_count", dv_cnt, 1);
        check_eq("single_dv_data", {24'd0, qd(0)}, 32'h90);
        check_eq("single_data_held", {24'd0, data}, 32'h90);
        check_eq("single_busy_low", {31'd0, busy}, 32'd0);

        clear_log();
        send(8'h90, BITP, 1'b1);
        send(8'h3C, BITP, 1'b1);
        send(8'h64, BITP, 1'b1);
        idle(400);
        check_eq("b2b_dv_count", dv_cnt, 3);
        check_eq("b2b_data0", {24'd0, qd(0)}, 32'h90);
        check_eq("b2b_data1", {24'd0, qd(1)}, 32'h3C);
        check_eq("b2b_data2", {24'd0, qd(2)}, 32'h64);
        check_eq("b2b_gap01", {31'd0, in_range(qt(1) - qt(0))}, 32'd1);
        check_eq("b2b_gap12", {31'd0, in_range(qt(2) - qt(1))}, 32'd1);

        clear_log();
        rx = 1'b0;
        repeat (60) @(negedge clk);
        check_eq("glitch_busy_high", {31'd0, busy}, 32'd1);
        rx = 1'b1;
        k = 0;
        while (busy === 1'b1 && k < BITP) begin
            @(negedge clk);
            k++;
        end
        check_eq("glitch_busy_fall", {31'd0, busy}, 32'd0);
        idle(200);
        check_eq("glitch_no_dv", dv_cnt, 0);
        send(8'h45, BITP, 1'b1);
        idle(400);
        check_eq("after_glitch_count", dv_cnt, 1);
        check_eq("after_glitch_data", {24'd0, qd(0)}, 32'h45);

        clear_log();
        send(8'hA5, BITP, 1'b0);
        rx = 1'b0;
        repeat (5 * BITP) @(negedge clk);
        idle(2 * BITP);
        check_eq("ferr_no_dv", dv_cnt, 0);
        check_eq("ferr_data_unchanged", {24'd0, data}, 32'h45);
`ifdef MIDI_RX_FERR_EN
        check_eq("ferr_pulses", ferr_cnt, 1);
        check_eq("ferr_err_cnt", {24'd0, err_cnt}, 32'd1);
`endif
        send(8'h12, BITP, 1'b1);
        idle(400);
        check_eq("after_ferr_count", dv_cnt, 1);
        check_eq("after_ferr_data", {24'd0, qd(0)}, 32'h12);

        clear_log();
        rx = 1'b0;
        repeat (BITP) @(negedge clk);
        rx = 1'b1;
        repeat (4 * BITP + BITP / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(2 * BITP);
        check_eq("rst_mid_no_dv", dv_cnt, 0);
        check_eq("rst_mid_data", {24'd0, data}, 32'h00);
        check_eq("rst_mid_busy", {31'd0, busy}, 32'd0);
        send(8'hC3, BITP, 1'b1);
        idle(400);
        check_eq("after_rst_count", dv_cnt, 1);
        check_eq("after_rst_data", {24'd0, qd(0)}, 32'hC3);

        for (int j = 0; j < 2; j++) begin
            clear_log();
            send(8'h7F, bps[j], 1'b1);
            idle(400);
            check_eq($sformatf("tol%0d_count", bps[j]), dv_cnt, 1);
            check_eq($sformatf("tol%0d_data", bps[j]), {24'd0, qd(0)}, 32'h7F);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
